// File: rtl/multislot_tracker_pkg.sv
// Shared types and helpers for the multi-slot TX/RX slot tracker.
package multislot_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TX   = 2'd1,
    ST_RX   = 2'd2
  } state_t;

  localparam logic [3:0] PK_NULL = 4'h0;
  localparam logic [3:0] PK_POLL = 4'h1;
  localparam logic [3:0] PK_FHS  = 4'h2;
  localparam logic [3:0] PK_DM1  = 4'h3;
  localparam logic [3:0] PK_DH1  = 4'h4;
  localparam logic [3:0] PK_HV1  = 4'h5;
  localparam logic [3:0] PK_HV2  = 4'h6;
  localparam logic [3:0] PK_HV3  = 4'h7;
  localparam logic [3:0] PK_DV   = 4'h8;
  localparam logic [3:0] PK_AUX1 = 4'h9;
  localparam logic [3:0] PK_DM3  = 4'hA;
  localparam logic [3:0] PK_DH3  = 4'hB;
  localparam logic [3:0] PK_EV4  = 4'hC;
  localparam logic [3:0] PK_EV5  = 4'hD;
  localparam logic [3:0] PK_DM5  = 4'hE;
  localparam logic [3:0] PK_DH5  = 4'hF;

  // Slot occupancy of a packet type, clamped to the configured cap.
  function automatic int unsigned slots(input logic [3:0] pk_type, input int unsigned maxslots);
    int unsigned n;
    if (pk_type >= PK_DM3 && pk_type <= PK_EV5) n = 3;
    else if (pk_type >= PK_DM5)                 n = 5;
    else                                        n = 1;
    return (n > maxslots) ? maxslots : n;
  endfunction

endpackage

// File: rtl/multislot_tracker_seq_cnt.sv
// 1-based slot counter shared by the TX and RX phases of the tracker.
module slot_seq_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstz,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] cmp_val,
  output logic [CW-1:0] cnt,
  output logic          eq
);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= CW'(1);
    else if (inc)  cnt <= cnt + CW'(1);
  end

  assign eq = (cnt == cmp_val);

endmodule

// File: rtl/multislot_tracker.sv
// Link-aware multi-slot TX/RX slot tracker: FSM, occupancy latches and slot flags.
module multislot_tracker
  import multislot_tracker_pkg::*;
#(
  parameter  int NLINK    = 8,
  parameter  int MAXSLOTS = 5,
  parameter  int CW       = 3,
  localparam int LW       = (NLINK > 1) ? $clog2(NLINK) : 1
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             ms_tslot_p,
  input  logic             ms_halftslot_p,
  input  logic             regi_isMaster,
  input  logic             corre_trgp,
  input  logic             tx_start,
  input  logic [3:0]       tx_pk_type,
  input  logic [LW-1:0]    link_sel,
  input  logic             rx_hdr_valid,
  input  logic [3:0]       rx_pk_type,
  input  logic             abort,
  output logic [CW-1:0]    tx_slots_f,
  output logic [CW-1:0]    rx_slots_f,
  output logic             txextendslot,
  output logic             rxextendslot,
  output logic             ms_TXslot_endp,
  output logic             ms_RXslot_endp,
  output logic             conns_rx1stslot,
  output logic             mask_corre_win,
  output logic [NLINK-1:0] link_busy,
  output logic             tx_start_err
);

  state_t           state, state_nxt;
  logic [LW-1:0]    link_q, link_nxt;
  logic [CW-1:0]    tx_slots_nxt, rx_slots_nxt, rx_slots_eff, cmp_val, cnt;
  logic             txext_nxt, rxext_nxt, rx1st_nxt, mask_nxt, err_nxt;
  logic [NLINK-1:0] busy_nxt;
  logic             cnt_clr, cnt_load, cnt_inc, cnt_eq;
  logic             hdr_load, link_ok;

  // A first-slot header takes effect in the same cycle so a coincident boundary sees it.
  assign hdr_load     = (state == ST_RX) && conns_rx1stslot && rx_hdr_valid;
  assign rx_slots_eff = hdr_load ? CW'(slots(rx_pk_type, MAXSLOTS)) : rx_slots_f;
  assign cmp_val      = (state == ST_TX) ? tx_slots_f : rx_slots_eff;
  assign link_ok      = ({1'b0, link_sel} < (LW+1)'(NLINK));

  assign ms_TXslot_endp = !abort && (state == ST_TX) && ms_tslot_p && cnt_eq;
  assign ms_RXslot_endp = !abort && (state == ST_RX) && ms_tslot_p && cnt_eq;

  slot_seq_cnt #(.CW(CW)) u_cnt (
    .clk     (clk_6M),
    .rstz    (rstz),
    .clr     (cnt_clr),
    .load    (cnt_load),
    .inc     (cnt_inc),
    .cmp_val (cmp_val),
    .cnt     (cnt),
    .eq      (cnt_eq)
  );

  always_comb begin
    state_nxt    = state;
    link_nxt     = link_q;
    tx_slots_nxt = tx_slots_f;
    rx_slots_nxt = rx_slots_f;
    txext_nxt    = txextendslot;
    rxext_nxt    = rxextendslot;
    rx1st_nxt    = conns_rx1stslot;
    mask_nxt     = mask_corre_win;
    err_nxt      = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_inc      = 1'b0;
    if (abort) begin
      state_nxt    = ST_IDLE;
      link_nxt     = '0;
      tx_slots_nxt = '0;
      rx_slots_nxt = '0;
      txext_nxt    = 1'b0;
      rxext_nxt    = 1'b0;
      rx1st_nxt    = 1'b0;
      mask_nxt     = 1'b0;
      cnt_clr      = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tx_start) begin
            if (link_ok) begin
              state_nxt    = ST_TX;
              tx_slots_nxt = CW'(slots(tx_pk_type, MAXSLOTS));
              link_nxt     = link_sel;
              cnt_load     = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (corre_trgp && !regi_isMaster) begin
            state_nxt    = ST_RX;
            rx_slots_nxt = CW'(1);
            rx1st_nxt    = 1'b1;
            cnt_load     = 1'b1;
          end
        end
        ST_TX: begin
          err_nxt = tx_start;
          if (ms_halftslot_p) begin
            if (cnt_eq)                                           mask_nxt = 1'b0;
            else if (tx_slots_f > CW'(1) && cnt == CW'(1))        mask_nxt = 1'b1;
          end
          if (ms_tslot_p) begin
            if (cnt_eq) begin
              txext_nxt = 1'b0;
              mask_nxt  = 1'b0;
              if (regi_isMaster) begin
                state_nxt    = ST_RX;
                rx_slots_nxt = CW'(1);
                rx1st_nxt    = 1'b1;
                cnt_load     = 1'b1;
              end else begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
              end
            end else begin
              txext_nxt = 1'b1;
              cnt_inc   = 1'b1;
            end
          end
        end
        ST_RX: begin
          err_nxt = tx_start;
          if (hdr_load) rx_slots_nxt = rx_slots_eff;
          if (ms_tslot_p) begin
            rx1st_nxt = 1'b0;
            if (cnt_eq) begin
              state_nxt = ST_IDLE;
              rxext_nxt = 1'b0;
              cnt_clr   = 1'b1;
            end else begin
              rxext_nxt = 1'b1;
              cnt_inc   = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    for (int i = 0; i < NLINK; i++)
      busy_nxt[i] = (state_nxt != ST_IDLE) && (link_nxt == LW'(i));
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state           <= ST_IDLE;
      link_q          <= '0;
      tx_slots_f      <= '0;
      rx_slots_f      <= '0;
      txextendslot    <= 1'b0;
      rxextendslot    <= 1'b0;
      conns_rx1stslot <= 1'b0;
      mask_corre_win  <= 1'b0;
      link_busy       <= '0;
      tx_start_err    <= 1'b0;
    end else begin
      state           <= state_nxt;
      link_q          <= link_nxt;
      tx_slots_f      <= tx_slots_nxt;
      rx_slots_f      <= rx_slots_nxt;
      txextendslot    <= txext_nxt;
      rxextendslot    <= rxext_nxt;
      conns_rx1stslot <= rx1st_nxt;
      mask_corre_win  <= mask_nxt;
      link_busy       <= busy_nxt;
      tx_start_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_multislot_tracker.sv
// Scoreboard bench for multislot_tracker: default instance plus a 6-link, 3-slot-cap instance.
module tb_multislot_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstz;

  logic       a_tslot, a_half, a_master, a_corre, a_start, a_hdr, a_abort, a_probe;
  logic [3:0] a_type, a_rxtype;
  logic [2:0] a_link;
  logic [2:0] a_txs, a_rxs;
  logic       a_txext, a_rxext, a_txe, a_rxe, a_r1, a_mask, a_err;
  logic [7:0] a_lb;

  logic       b_tslot, b_master, b_corre, b_start, b_abort, b_probe;
  logic [3:0] b_type;
  logic [2:0] b_link;
  logic [2:0] b_txs, b_rxs;
  logic       b_txext, b_rxext, b_txe, b_rxe, b_r1, b_mask, b_err;
  logic [5:0] b_lb;

  multislot_tracker u_a (
    .clk_6M(clk), .rstz(rstz), .ms_tslot_p(a_tslot), .ms_halftslot_p(a_half),
    .regi_isMaster(a_master), .corre_trgp(a_corre), .tx_start(a_start),
    .tx_pk_type(a_type), .link_sel(a_link), .rx_hdr_valid(a_hdr), .rx_pk_type(a_rxtype),
    .abort(a_abort), .tx_slots_f(a_txs), .rx_slots_f(a_rxs), .txextendslot(a_txext),
    .rxextendslot(a_rxext), .ms_TXslot_endp(a_txe), .ms_RXslot_endp(a_rxe),
    .conns_rx1stslot(a_r1), .mask_corre_win(a_mask), .link_busy(a_lb), .tx_start_err(a_err)
  );

  multislot_tracker #(.NLINK(6), .MAXSLOTS(3), .CW(3)) u_b (
    .clk_6M(clk), .rstz(rstz), .ms_tslot_p(b_tslot), .ms_halftslot_p(1'b0),
    .regi_isMaster(b_master), .corre_trgp(b_corre), .tx_start(b_start),
    .tx_pk_type(b_type), .link_sel(b_link), .rx_hdr_valid(1'b0), .rx_pk_type(4'h0),
    .abort(b_abort), .tx_slots_f(b_txs), .rx_slots_f(b_rxs), .txextendslot(b_txext),
    .rxextendslot(b_rxext), .ms_TXslot_endp(b_txe), .ms_RXslot_endp(b_rxe),
    .conns_rx1stslot(b_r1), .mask_corre_win(b_mask), .link_busy(b_lb), .tx_start_err(b_err)
  );

  typedef struct {
    logic       txe, rxe, err, txext, rxext, r1, mask;
    logic [2:0] txs, rxs;
    logic [7:0] lb;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string p, input rec_t e, input rec_t a);
    chk({p, "_txendp"}, {7'd0, a.txe},   {7'd0, e.txe});
    chk({p, "_rxendp"}, {7'd0, a.rxe},   {7'd0, e.rxe});
    chk({p, "_txerr"},  {7'd0, a.err},   {7'd0, e.err});
    chk({p, "_txext"},  {7'd0, a.txext}, {7'd0, e.txext});
    chk({p, "_rxext"},  {7'd0, a.rxext}, {7'd0, e.rxext});
    chk({p, "_rx1st"},  {7'd0, a.r1},    {7'd0, e.r1});
    chk({p, "_mask"},   {7'd0, a.mask},  {7'd0, e.mask});
    chk({p, "_txslots"}, {5'd0, a.txs},  {5'd0, e.txs});
    chk({p, "_rxslots"}, {5'd0, a.rxs},  {5'd0, e.rxs});
    chk({p, "_linkbusy"}, a.lb, e.lb);
  endtask

  always @(negedge clk) begin
    if (rstz && (a_probe || a_txe || a_rxe || a_err)) begin
      rec_t act;
      act = '{a_txe, a_rxe, a_err, a_txext, a_rxext, a_r1, a_mask, a_txs, a_rxs, a_lb};
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_event actual=txe%b rxe%b err%b required=none at %0t",
                 a_txe, a_rxe, a_err, $time);
      end else begin
        cmp("a", qa.pop_front(), act);
      end
    end
  end

  always @(negedge clk) begin
    if (rstz && (b_probe || b_txe || b_rxe || b_err)) begin
      rec_t act;
      act = '{b_txe, b_rxe, b_err, b_txext, b_rxext, b_r1, b_mask, b_txs, b_rxs, {2'b00, b_lb}};
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_event actual=txe%b rxe%b err%b required=none at %0t",
                 b_txe, b_rxe, b_err, $time);
      end else begin
        cmp("b", qb.pop_front(), act);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    a_tslot = 0; a_half = 0; a_corre = 0; a_start = 0; a_hdr = 0; a_abort = 0; a_probe = 0;
    b_tslot = 0; b_corre = 0; b_start = 0; b_abort = 0; b_probe = 0;
  endtask

  task automatic ea(input logic txe, rxe, err, txext, rxext, r1, mask,
                    input logic [2:0] txs, rxs, input logic [7:0] lb);
    qa.push_back('{txe, rxe, err, txext, rxext, r1, mask, txs, rxs, lb});
    a_probe = 1;
  endtask

  task automatic eb(input logic txe, rxe, err, txext, rxext, r1, mask,
                    input logic [2:0] txs, rxs, input logic [7:0] lb);
    qb.push_back('{txe, rxe, err, txext, rxext, r1, mask, txs, rxs, lb});
    b_probe = 1;
  endtask

  initial begin
    rstz = 0;
    a_tslot = 0; a_half = 0; a_master = 0; a_corre = 0; a_start = 0; a_hdr = 0;
    a_abort = 0; a_probe = 0; a_type = 0; a_rxtype = 0; a_link = 0;
    b_tslot = 0; b_master = 0; b_corre = 0; b_start = 0; b_abort = 0; b_probe = 0;
    b_type = 0; b_link = 0;
    repeat (3) @(posedge clk);
    #1 rstz = 1;

    ea(0,0,0, 0,0,0,0, 3'd0,3'd0, 8'h00);
    eb(0,0,0, 0,0,0,0, 3'd0,3'd0, 8'h00);
    step();

    // single-slot master exchange, no RX header
    a_master = 1; a_start = 1; a_type = 4'h4; a_link = 3'd0; step();
    ea(0,0,0, 0,0,0,0, 3'd1,3'd0, 8'h01); step();
    a_tslot = 1; ea(1,0,0, 0,0,0,0, 3'd1,3'd0, 8'h01); step();
    ea(0,0,0, 0,0,1,0, 3'd1,3'd1, 8'h01); step();
    a_tslot = 1; ea(0,1,0, 0,0,1,0, 3'd1,3'd1, 8'h01); step();
    ea(0,0,0, 0,0,0,0, 3'd1,3'd1, 8'h00); step();

    // five-slot TX on link 3, correlator mask, then 3-slot RX from header 0xB
    a_start = 1; a_type = 4'hF; a_link = 3'd3; step();
    a_half = 1; ea(0,0,0, 0,0,0,0, 3'd5,3'd1, 8'h08); step();
    ea(0,0,0, 0,0,0,1, 3'd5,3'd1, 8'h08); step();
    a_tslot = 1; step();
    ea(0,0,0, 1,0,0,1, 3'd5,3'd1, 8'h08); step();
    repeat (3) begin a_tslot = 1; step(); end
    a_half = 1; step();
    ea(0,0,0, 1,0,0,0, 3'd5,3'd1, 8'h08); step();
    a_tslot = 1; ea(1,0,0, 1,0,0,0, 3'd5,3'd1, 8'h08); step();
    a_hdr = 1; a_rxtype = 4'hB; ea(0,0,0, 0,0,1,0, 3'd5,3'd1, 8'h08); step();
    ea(0,0,0, 0,0,1,0, 3'd5,3'd3, 8'h08); step();
    a_tslot = 1; step();
    a_tslot = 1; a_hdr = 1; a_rxtype = 4'h0; ea(0,0,0, 0,1,0,0, 3'd5,3'd3, 8'h08); step();
    a_tslot = 1; ea(0,1,0, 0,1,0,0, 3'd5,3'd3, 8'h08); step();
    ea(0,0,0, 0,0,0,0, 3'd5,3'd3, 8'h00); step();

    // slave RX, header 0xE arrives together with the first boundary
    a_master = 0; a_corre = 1; step();
    a_hdr = 1; a_rxtype = 4'hE; a_tslot = 1; ea(0,0,0, 0,0,1,0, 3'd5,3'd1, 8'h08); step();
    ea(0,0,0, 0,1,0,0, 3'd5,3'd5, 8'h08); step();
    repeat (3) begin a_tslot = 1; step(); end
    a_tslot = 1; ea(0,1,0, 0,1,0,0, 3'd5,3'd5, 8'h08); step();
    ea(0,0,0, 0,0,0,0, 3'd5,3'd5, 8'h00); step();

    // abort on the final TX boundary, then tx_start while in RX
    a_master = 1; a_start = 1; a_type = 4'hA; a_link = 3'd5; step();
    a_tslot = 1; step();
    a_tslot = 1; ea(0,0,0, 1,0,0,0, 3'd3,3'd5, 8'h20); step();
    a_tslot = 1; a_abort = 1; ea(0,0,0, 1,0,0,0, 3'd3,3'd5, 8'h20); step();
    ea(0,0,0, 0,0,0,0, 3'd0,3'd0, 8'h00); step();
    a_start = 1; a_type = 4'h0; a_link = 3'd1; step();
    a_tslot = 1; ea(1,0,0, 0,0,0,0, 3'd1,3'd0, 8'h02); step();
    a_start = 1; ea(0,0,0, 0,0,1,0, 3'd1,3'd1, 8'h02); step();
    ea(0,0,1, 0,0,1,0, 3'd1,3'd1, 8'h02); step();
    a_tslot = 1; ea(0,1,0, 0,0,1,0, 3'd1,3'd1, 8'h02); step();
    ea(0,0,0, 0,0,0,0, 3'd1,3'd1, 8'h00); step();

    // illegal link, then start beating corre_trgp and a boundary; capped occupancy
    b_master = 1; b_start = 1; b_type = 4'hF; b_link = 3'd7; step();
    eb(0,0,1, 0,0,0,0, 3'd0,3'd0, 8'h00); step();
    b_start = 1; b_link = 3'd2; b_corre = 1; b_tslot = 1; eb(0,0,0, 0,0,0,0, 3'd0,3'd0, 8'h00); step();
    eb(0,0,0, 0,0,0,0, 3'd3,3'd0, 8'h04); step();
    b_tslot = 1; step();
    b_tslot = 1; step();
    b_tslot = 1; eb(1,0,0, 1,0,0,0, 3'd3,3'd0, 8'h04); step();
    eb(0,0,0, 0,0,1,0, 3'd3,3'd1, 8'h04); step();
    b_tslot = 1; eb(0,1,0, 0,0,1,0, 3'd3,3'd1, 8'h04); step();
    eb(0,0,0, 0,0,0,0, 3'd3,3'd1, 8'h00); step();

    repeat (2) step();
    chk("a_pending_expectations", 8'(qa.size()), 8'd0);
    chk("b_pending_expectations", 8'(qb.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
